// File: rtl/tiranga_pkg.sv
// Shared types and constants for the tiranga flag sequencer.
//   state_t      : sequencer states IDLE, SAFFRON, WHITE, GREEN, DONE
//   BAND_*       : encodings driven on band_o
package tiranga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAFFRON,
        WHITE,
        GREEN,
        DONE
    } state_t;

    localparam logic [1:0] BAND_NONE    = 2'd0;
    localparam logic [1:0] BAND_SAFFRON = 2'd1;
    localparam logic [1:0] BAND_WHITE   = 2'd2;
    localparam logic [1:0] BAND_GREEN   = 2'd3;

endpackage

// File: rtl/tiranga_window.sv
// Chakra window decode for the white band.
//   cnt      : cycle index within the current band (registered upstream)
//   in_white : high while the sequencer is in WHITE
//   chakra0  : inner window, MID-CHAKRA_INNER <= cnt <= MID+CHAKRA_INNER
//   chakra1  : outer ring between the inner window and MID+/-CHAKRA_OUTER
module tiranga_window #(
    parameter int unsigned BAND_CYCLES  = 300,
    parameter int unsigned CHAKRA_INNER = 30,
    parameter int unsigned CHAKRA_OUTER = 50
) (
    input  logic [15:0] cnt,
    input  logic        in_white,
    output logic        chakra0,
    output logic        chakra1
);

    // Bounds stay non-negative because BAND_CYCLES >= 2*CHAKRA_OUTER+2.
    localparam logic [15:0] IN_LO  = 16'(BAND_CYCLES / 2 - CHAKRA_INNER);
    localparam logic [15:0] IN_HI  = 16'(BAND_CYCLES / 2 + CHAKRA_INNER);
    localparam logic [15:0] OUT_LO = 16'(BAND_CYCLES / 2 - CHAKRA_OUTER);
    localparam logic [15:0] OUT_HI = 16'(BAND_CYCLES / 2 + CHAKRA_OUTER);

    logic inner;
    logic lower_ring;
    logic upper_ring;

    always_comb begin
        inner      = (cnt >= IN_LO) && (cnt <= IN_HI);
        lower_ring = (cnt >= OUT_LO) && (cnt < IN_LO);
        upper_ring = (cnt > IN_HI) && (cnt <= OUT_HI);
        chakra0    = in_white && inner;
        chakra1    = in_white && (lower_ring || upper_ring);
    end

endmodule

// File: rtl/tiranga_seq.sv
// Flag sequencer: one start request plays saffron, white and green bands of
// BAND_CYCLES cycles each, then a single DONE cycle, then returns to IDLE.
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   start_i   : start request, honoured only in IDLE without abort_i
//   abort_i   : drop back to IDLE from any band state
//   busy_o    : high in SAFFRON, WHITE and GREEN
//   done_o    : one-cycle pulse in DONE
//   band_o    : 0 none, 1 saffron, 2 white, 3 green
//   chakra0_o : inner chakra window (white band only)
//   chakra1_o : outer chakra ring (white band only)
//   cnt_o     : cycle index within the current band
module tiranga_seq
    import tiranga_pkg::*;
#(
    parameter int unsigned BAND_CYCLES  = 300,
    parameter int unsigned CHAKRA_INNER = 30,
    parameter int unsigned CHAKRA_OUTER = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  band_o,
    output logic        chakra0_o,
    output logic        chakra1_o,
    output logic [15:0] cnt_o
);

    localparam logic [15:0] LAST = 16'(BAND_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs decode only the registered state and cnt.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        band_o     = BAND_NONE;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (start_i && !abort_i) begin
                    state_next = SAFFRON;
                end
            end
            SAFFRON, WHITE, GREEN: begin
                busy_o = 1'b1;
                case (state)
                    SAFFRON: band_o = BAND_SAFFRON;
                    WHITE:   band_o = BAND_WHITE;
                    default: band_o = BAND_GREEN;
                endcase
                if (abort_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == LAST) begin
                    cnt_next = '0;
                    case (state)
                        SAFFRON: state_next = WHITE;
                        WHITE:   state_next = GREEN;
                        default: state_next = DONE;
                    endcase
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign cnt_o = cnt;

    tiranga_window #(
        .BAND_CYCLES  (BAND_CYCLES),
        .CHAKRA_INNER (CHAKRA_INNER),
        .CHAKRA_OUTER (CHAKRA_OUTER)
    ) u_window (
        .cnt      (cnt),
        .in_white (state == WHITE),
        .chakra0  (chakra0_o),
        .chakra1  (chakra1_o)
    );

endmodule

// File: tb/tb_tiranga_seq.sv
// Bench for tiranga_seq: an elapsed-time model of the flag run is compared
// against every output on every cycle, plus literal spot checks of the
// documented timeline and chakra window edges.
module tb_tiranga_seq;

    localparam int B   = 300;
    localparam int CI  = 30;
    localparam int CO  = 50;
    localparam int MID = B / 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  band_o;
    logic        chakra0_o;
    logic        chakra1_o;
    logic [15:0] cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: whether a run is active and how many cycles since SAFFRON began.
    bit m_active = 0;
    int m_e      = 0;
    bit model_on = 0;

    always #5 clk = ~clk;

    tiranga_seq #(
        .BAND_CYCLES  (B),
        .CHAKRA_INNER (CI),
        .CHAKRA_OUTER (CO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .band_o    (band_o),
        .chakra0_o (chakra0_o),
        .chakra1_o (chakra1_o),
        .cnt_o     (cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_active = 0;
            m_e      = 0;
        end else if (m_active) begin
            if (m_e < 3 * B && abort_i) m_active = 0;
            else if (m_e >= 3 * B)      m_active = 0;
            else                        m_e++;
        end else if (start_i && !abort_i) begin
            m_active = 1;
            m_e      = 0;
        end
        model_on = 1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            int ebusy, edone, eband, ecnt, ec0, ec1, d;
            ebusy = 0; edone = 0; eband = 0; ecnt = 0; ec0 = 0; ec1 = 0;
            if (m_active && m_e < 3 * B) begin
                ebusy = 1;
                eband = m_e / B + 1;
                ecnt  = m_e % B;
                if (eband == 2) begin
                    d = ecnt - MID;
                    if (d < 0) d = -d;
                    ec0 = (d <= CI) ? 1 : 0;
                    ec1 = (d > CI && d <= CO) ? 1 : 0;
                end
            end else if (m_active) begin
                edone = 1;
            end
            chk("busy",    32'(busy_o),    32'(ebusy));
            chk("done",    32'(done_o),    32'(edone));
            chk("band",    32'(band_o),    32'(eband));
            chk("cnt",     32'(cnt_o),     32'(ecnt));
            chk("chakra0", 32'(chakra0_o), 32'(ec0));
            chk("chakra1", 32'(chakra1_o), 32'(ec1));
        end
    end

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d expected %0d", cyc, target);
        end
    endtask

    // Raises start_i for one sampling edge; returns the cycle it was raised in.
    task automatic pulse_start(output int t0);
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic pulse_abort;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
    endtask

    initial begin
        int t0;
        reset   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_band", 32'(band_o), 32'd0);
        chk("reset_cnt",  32'(cnt_o),  32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Scenario 1: full run timeline
        pulse_start(t0);
        chk("s1_band_c1", 32'(band_o), 32'd1);
        chk("s1_cnt_c1",  32'(cnt_o),  32'd0);
        wait_cyc(t0 + 300);
        chk("s1_band_c300", 32'(band_o), 32'd1);
        chk("s1_cnt_c300",  32'(cnt_o),  32'd299);
        wait_cyc(t0 + 301);
        chk("s1_band_c301", 32'(band_o), 32'd2);
        // Scenario 2: chakra window edges in WHITE (cnt k at t0+301+k)
        wait_cyc(t0 + 301 + 99);
        chk("s2_c0_99",  32'(chakra0_o), 32'd0);
        chk("s2_c1_99",  32'(chakra1_o), 32'd0);
        wait_cyc(t0 + 301 + 100);
        chk("s2_c1_100", 32'(chakra1_o), 32'd1);
        wait_cyc(t0 + 301 + 119);
        chk("s2_c1_119", 32'(chakra1_o), 32'd1);
        chk("s2_c0_119", 32'(chakra0_o), 32'd0);
        wait_cyc(t0 + 301 + 120);
        chk("s2_c0_120", 32'(chakra0_o), 32'd1);
        chk("s2_c1_120", 32'(chakra1_o), 32'd0);
        wait_cyc(t0 + 301 + 180);
        chk("s2_c0_180", 32'(chakra0_o), 32'd1);
        wait_cyc(t0 + 301 + 181);
        chk("s2_c0_181", 32'(chakra0_o), 32'd0);
        chk("s2_c1_181", 32'(chakra1_o), 32'd1);
        wait_cyc(t0 + 301 + 200);
        chk("s2_c1_200", 32'(chakra1_o), 32'd1);
        wait_cyc(t0 + 301 + 201);
        chk("s2_c1_201", 32'(chakra1_o), 32'd0);
        chk("s2_c0_201", 32'(chakra0_o), 32'd0);
        wait_cyc(t0 + 600);
        chk("s1_band_c600", 32'(band_o), 32'd2);
        wait_cyc(t0 + 601);
        chk("s1_band_c601", 32'(band_o), 32'd3);
        wait_cyc(t0 + 900);
        chk("s1_band_c900", 32'(band_o), 32'd3);
        chk("s1_done_c900", 32'(done_o), 32'd0);
        wait_cyc(t0 + 901);
        chk("s1_done_c901", 32'(done_o), 32'd1);
        chk("s1_band_c901", 32'(band_o), 32'd0);
        chk("s1_busy_c901", 32'(busy_o), 32'd0);
        wait_cyc(t0 + 902);
        chk("s1_busy_c902", 32'(busy_o), 32'd0);
        chk("s1_done_c902", 32'(done_o), 32'd0);
        repeat (3) @(negedge clk);

        // Scenario 3: abort at WHITE cnt=10, then restart
        pulse_start(t0);
        wait_cyc(t0 + 311);
        chk("s3_band_pre", 32'(band_o), 32'd2);
        chk("s3_cnt_pre",  32'(cnt_o),  32'd10);
        pulse_abort();
        chk("s3_band_post", 32'(band_o), 32'd0);
        chk("s3_busy_post", 32'(busy_o), 32'd0);
        chk("s3_cnt_post",  32'(cnt_o),  32'd0);
        repeat (5) @(negedge clk);
        pulse_start(t0);
        chk("s3_restart_band", 32'(band_o), 32'd1);
        repeat (4) @(negedge clk);
        pulse_abort();
        repeat (2) @(negedge clk);

        // Scenario 4: re-pulses of start during SAFFRON and DONE are ignored
        pulse_start(t0);
        wait_cyc(t0 + 6);
        chk("s4_cnt5", 32'(cnt_o), 32'd5);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("s4_cnt6", 32'(cnt_o), 32'd6);
        wait_cyc(t0 + 901);
        chk("s4_done", 32'(done_o), 32'd1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("s4_busy_c902", 32'(busy_o), 32'd0);
        chk("s4_band_c902", 32'(band_o), 32'd0);
        @(negedge clk);
        chk("s4_busy_c903", 32'(busy_o), 32'd0);

        // Scenario 5: reset at GREEN cnt=50 with start held
        pulse_start(t0);
        wait_cyc(t0 + 651);
        chk("s5_band_pre", 32'(band_o), 32'd3);
        chk("s5_cnt_pre",  32'(cnt_o),  32'd50);
        reset   = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        reset   = 1'b1;
        start_i = 1'b0;
        chk("s5_busy", 32'(busy_o), 32'd0);
        chk("s5_band", 32'(band_o), 32'd0);
        chk("s5_cnt",  32'(cnt_o),  32'd0);
        chk("s5_done", 32'(done_o), 32'd0);
        @(negedge clk);
        chk("s5_still_idle", 32'(busy_o), 32'd0);

        // Scenario 6: start and abort together in IDLE
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("s6_busy", 32'(busy_o), 32'd0);
        chk("s6_band", 32'(band_o), 32'd0);
        @(negedge clk);
        chk("s6_busy_next", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiranga_seq.md
TIRANGA_SEQ -- requirements
Module: tiranga_seq

Interface
REQ-001 SHALL have parameter BAND_CYCLES, default 300: cycles per band; legal range 2*CHAKRA_OUTER+2 to 65535.
REQ-002 SHALL have parameter CHAKRA_INNER, default 30: half-width of the chakra0 window.
REQ-003 SHALL have parameter CHAKRA_OUTER, default 50: half-width of the chakra1 outer edge; CHAKRA_OUTER > CHAKRA_INNER.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1: request one flag sequence; sampled only in IDLE.
REQ-007 SHALL have port abort_i  input  1: terminate the sequence in progress.
REQ-008 SHALL have port busy_o  output  1: high in SAFFRON, WHITE and GREEN.
REQ-009 SHALL have port done_o  output  1: single-cycle pulse on normal completion.
REQ-010 SHALL have port band_o  output  2: 0 none, 1 saffron, 2 white, 3 green.
REQ-011 SHALL have port chakra0_o  output  1: inner chakra window, white band only.
REQ-012 SHALL have port chakra1_o  output  1: outer chakra ring, white band only.
REQ-013 SHALL have port cnt_o  output  16: cycle index within the current band.

Function
REQ-014 SHALL implement the FSM IDLE -> SAFFRON -> WHITE -> GREEN -> DONE -> IDLE.
REQ-015 In IDLE with start_i=1 and abort_i=0, SHALL enter SAFFRON next cycle with cnt=0.
REQ-016 In each band state, cnt SHALL increment by 1 per cycle; at cnt=BAND_CYCLES-1 the FSM SHALL advance to the next state with cnt=0.
REQ-017 A full run SHALL last exactly 3*BAND_CYCLES cycles of busy_o=1, followed by exactly one DONE cycle with done_o=1.
REQ-018 DONE SHALL return to IDLE unconditionally; a start_i asserted in DONE SHALL be ignored.
REQ-019 start_i asserted while busy_o=1 SHALL be ignored, with no queuing.
REQ-020 abort_i=1 in any band state SHALL force IDLE and cnt=0 next cycle, with no done_o pulse.
REQ-021 When start_i and abort_i are both high in IDLE, abort_i SHALL win and the FSM SHALL stay in IDLE.
REQ-022 band_o SHALL be 1, 2 or 3 in SAFFRON, WHITE or GREEN respectively, and 0 in IDLE and DONE.
REQ-023 With MID=BAND_CYCLES/2 (integer division), chakra0_o SHALL be 1 in WHITE when MID-CHAKRA_INNER <= cnt <= MID+CHAKRA_INNER.
REQ-024 chakra1_o SHALL be 1 in WHITE when MID-CHAKRA_OUTER <= cnt < MID-CHAKRA_INNER, or when MID+CHAKRA_INNER < cnt <= MID+CHAKRA_OUTER.
REQ-025 chakra0_o and chakra1_o SHALL never both be 1, and SHALL be 0 outside WHITE.
REQ-026 All outputs SHALL be functions of state and cnt registers only; there SHALL be no combinational path from any input or from clk.
REQ-027 The cnt comparison SHALL be unsigned 16-bit, and cnt SHALL never wrap within a band.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, cnt=0, busy_o=0, done_o=0, band_o=0, chakra0_o=0 and chakra1_o=0, including mid-sequence.
REQ-029 start_i SHALL be ignored during any cycle in which reset=0.

Structure
REQ-030 Package tiranga_pkg SHALL hold the state enum (IDLE, SAFFRON, WHITE, GREEN, DONE) and the band_o encoding constants.
REQ-031 The window comparisons SHALL live in the sub-module tiranga_window, with inputs cnt and an in_white flag, outputs chakra0 and chakra1, and parameters BAND_CYCLES, CHAKRA_INNER and CHAKRA_OUTER.

Verification (defaults: BAND=300, MID=150)
REQ-032 Scenario 1: pulse start_i at cycle 0 -> band_o=1 for cycles 1-300, 2 for 301-600, 3 for 601-900; done_o=1 at cycle 901 only; busy_o=0 at cycle 902.
REQ-033 Scenario 2: in WHITE -> chakra0_o=1 for cnt 120..180; chakra1_o=1 for cnt 100..119 and 181..200; both 0 at cnt 99 and 201.
REQ-034 Scenario 3: abort_i at WHITE cnt=10 -> IDLE with band_o=0 next cycle, no done_o pulse, and a subsequent start_i is accepted.
REQ-035 Scenario 4: start_i re-pulsed at SAFFRON cnt=5 and during DONE -> ignored, and the timeline is unchanged from Scenario 1.
REQ-036 Scenario 5: reset=0 for one cycle at GREEN cnt=50 -> all outputs 0 next cycle; a start_i held together with reset=0 is not accepted.
REQ-037 Scenario 6: start_i=1 and abort_i=1 together in IDLE -> FSM stays in IDLE and busy_o=0.
